// File: rtl/dcn_pkg.sv
// Shared definitions for the deformable-conv datapath: default widths,
// bilinear weight type, sampler state encoding and the round/saturate helper.
package dcn_pkg;

  localparam int DCN_DATA_W    = 16;
  localparam int DCN_FRAC_BITS = 8;
  localparam int DCN_ACC_W     = DCN_DATA_W + 2 * DCN_FRAC_BITS + 3;

  // Unsigned bilinear weight; one extra bit so ONE*ONE is representable.
  typedef logic [2*DCN_FRAC_BITS:0] weight_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LAST  = 2'd2,
    OUT   = 2'd3
  } sampler_state_t;

  // Round half up, drop 2*FRAC_BITS fraction bits, clamp to the signed sample range.
  function automatic logic signed [DCN_DATA_W-1:0] round_sat(
    input logic signed [DCN_ACC_W-1:0] acc
  );
    logic signed [DCN_ACC_W-1:0] biased;
    logic signed [DCN_ACC_W-1:0] shifted;
    logic signed [DCN_ACC_W-1:0] max_v;
    logic signed [DCN_ACC_W-1:0] min_v;
    max_v   = DCN_ACC_W'((1 << (DCN_DATA_W - 1)) - 1);
    min_v   = ~max_v;
    biased  = acc + (DCN_ACC_W'(1) <<< (2 * DCN_FRAC_BITS - 1));
    shifted = biased >>> (2 * DCN_FRAC_BITS);
    if (shifted > max_v) begin
      return max_v[DCN_DATA_W-1:0];
    end else if (shifted < min_v) begin
      return min_v[DCN_DATA_W-1:0];
    end else begin
      return shifted[DCN_DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/bilinear_weight_gen.sv
// Combinational bilinear weight generator: fractions -> four unsigned weights
// that always sum to ONE*ONE.
module bilinear_weight_gen
  import dcn_pkg::*;
#(
  parameter int FRAC_BITS = DCN_FRAC_BITS
) (
  input  logic [FRAC_BITS-1:0] frac_x,
  input  logic [FRAC_BITS-1:0] frac_y,
  output logic [2*FRAC_BITS:0] w00,
  output logic [2*FRAC_BITS:0] w01,
  output logic [2*FRAC_BITS:0] w10,
  output logic [2*FRAC_BITS:0] w11
);

  localparam int W_W = 2 * FRAC_BITS + 1;

  logic [W_W-1:0] one_w;
  logic [W_W-1:0] fx_w;
  logic [W_W-1:0] fy_w;
  logic [W_W-1:0] ifx_w;
  logic [W_W-1:0] ify_w;

  // Products fit in W_W bits: the largest is (ONE)*(ONE).
  always_comb begin
    one_w = W_W'(1) << FRAC_BITS;
    fx_w  = W_W'(frac_x);
    fy_w  = W_W'(frac_y);
    ifx_w = one_w - fx_w;
    ify_w = one_w - fy_w;
    w00   = ifx_w * ify_w;
    w01   = fx_w * ify_w;
    w10   = ifx_w * fy_w;
    w11   = fx_w * fy_w;
  end

endmodule

// File: rtl/bilinear_sampler.sv
// Bilinear sampler: accepts one clipped sampling point, reads the four
// neighbouring pixels through a 1-cycle-latency port, and returns one
// rounded, saturated interpolated sample.
module bilinear_sampler
  import dcn_pkg::*;
#(
  parameter int DATA_W    = DCN_DATA_W,
  parameter int FRAC_BITS = DCN_FRAC_BITS,
  parameter int IDX_W     = 4,
  parameter int MAX_X     = 16,
  parameter int MAX_Y     = 16,
  parameter int ADDR_W    = $clog2(MAX_X * MAX_Y)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDX_W-1:0]     base_x,
  input  logic [IDX_W-1:0]     base_y,
  input  logic [FRAC_BITS-1:0] frac_x,
  input  logic [FRAC_BITS-1:0] frac_y,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data
);

  localparam int W_W    = 2 * FRAC_BITS + 1;
  localparam int PROD_W = DATA_W + 2 * FRAC_BITS + 2;
  localparam int ACC_W  = DATA_W + 2 * FRAC_BITS + 3;

  sampler_state_t           state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]         x_q, x_d;
  logic [IDX_W-1:0]         y_q, y_d;
  logic [W_W-1:0]           w_q [4];
  logic [W_W-1:0]           w_d [4];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        out_q, out_d;

  logic [W_W-1:0]           w00_c, w01_c, w10_c, w11_c;
  logic [IDX_W-1:0]         x1, y1, rx, ry;
  logic [1:0]               sel;
  logic [W_W-1:0]           w_sel;
  logic signed [PROD_W-1:0] pix_ext, w_ext, prod;
  logic signed [ACC_W-1:0]  acc_sum;

  bilinear_weight_gen #(
    .FRAC_BITS (FRAC_BITS)
  ) u_weight_gen (
    .frac_x (frac_x),
    .frac_y (frac_y),
    .w00    (w00_c),
    .w01    (w01_c),
    .w10    (w10_c),
    .w11    (w11_c)
  );

  // Neighbour coordinates with defensive clamping, and the read address per fetch slot.
  always_comb begin
    x1 = (int'(x_q) >= MAX_X - 1) ? IDX_W'(MAX_X - 1) : x_q + IDX_W'(1);
    y1 = (int'(y_q) >= MAX_Y - 1) ? IDX_W'(MAX_Y - 1) : y_q + IDX_W'(1);
    rx = cnt_q[0] ? x1 : x_q;
    ry = cnt_q[1] ? y1 : y_q;
    rd_en   = (state_q == FETCH);
    rd_addr = rd_en ? (ADDR_W'(ry) * ADDR_W'(MAX_X) + ADDR_W'(rx)) : '0;
  end

  // Weighted product of the pixel returning this cycle; read data lags the
  // fetch counter by one, so LAST consumes slot 3.
  always_comb begin
    sel     = (state_q == LAST) ? 2'd3 : cnt_q - 2'd1;
    w_sel   = w_q[sel];
    pix_ext = PROD_W'($signed(rd_data));
    w_ext   = PROD_W'({1'b0, w_sel});
    prod    = pix_ext * w_ext;
    acc_sum = acc_q + ACC_W'(prod);
  end

  // Next-state and datapath update for the request sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = base_x;
          y_d     = base_y;
          w_d[0]  = w00_c;
          w_d[1]  = w01_c;
          w_d[2]  = w10_c;
          w_d[3]  = w11_c;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (cnt_q != 2'd0) begin
          acc_d = acc_sum;
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = LAST;
        end
      end
      LAST: begin
        acc_d   = acc_sum;
        out_d   = round_sat(acc_sum);
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '{default: '0};
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_q;

endmodule

// File: tb/tb_bilinear_sampler.sv
// Scoreboard bench for bilinear_sampler: a tile-buffer model answers reads,
// the stimulus thread queues expected addresses and results, and a monitor
// thread pops and compares them as the DUT presents them.
module tb_bilinear_sampler;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b1;
  logic [3:0]         base_x = '0;
  logic [3:0]         base_y = '0;
  logic [7:0]         frac_x = '0;
  logic [7:0]         frac_y = '0;
  logic               in_ready;
  logic               rd_en;
  logic [7:0]         rd_addr;
  logic signed [15:0] rd_data;
  logic               out_valid;
  logic signed [15:0] out_data;

  logic signed [15:0] mem [256];
  int exp_q[$];
  int addr_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bilinear_sampler #(
    .DATA_W    (16),
    .FRAC_BITS (8),
    .IDX_W     (4),
    .MAX_X     (16),
    .MAX_Y     (16),
    .ADDR_W    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .base_x    (base_x),
    .base_y    (base_y),
    .frac_x    (frac_x),
    .frac_y    (frac_y),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Tile buffer model: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  task automatic put(input int x, input int y, input int v);
    mem[y * 16 + x] = v[15:0];
  endtask

  task automatic set_px(input int x, input int y, input int p00, input int p01,
                        input int p10, input int p11);
    put(x, y, p00);
    put(x + 1, y, p01);
    put(x, y + 1, p10);
    put(x + 1, y + 1, p11);
  endtask

  // Queue expectations, then handshake one point; returns at cycle 1 (+1).
  task automatic send(input int x, input int y, input int fx, input int fy, input int exp);
    int x1;
    int y1;
    bit accepted;
    x1 = clampi(x + 1, 15);
    y1 = clampi(y + 1, 15);
    addr_q.push_back(y * 16 + x);
    addr_q.push_back(y * 16 + x1);
    addr_q.push_back(y1 * 16 + x);
    addr_q.push_back(y1 * 16 + x1);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b1;
    base_x   = 4'(x);
    base_y   = 4'(y);
    frac_x   = 8'(fx);
    frac_y   = 8'(fy);
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) chk("accept_timeout", int'(accepted), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    base_x   = 4'hA;
    base_y   = 4'h5;
    frac_x   = 8'h3C;
    frac_y   = 8'hC3;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", exp_q.size(), 0);
      exp_q.delete();
      addr_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compare read addresses and accepted results against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rd_en) begin
          if (addr_q.size() == 0) chk("rd_unexpected", addr_q.size(), 1);
          else chk("rd_addr", int'(rd_addr), addr_q.pop_front());
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("out_unexpected", exp_q.size(), 1);
          else chk("out_data", int'(out_data), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);

    // Centre sample with latency profile.
    set_px(2, 3, 100, 200, 300, 400);
    send(2, 3, 128, 128, 250);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("rd_en_c%0d", k), int'(rd_en), (k <= 4) ? 1 : 0);
      chk($sformatf("out_valid_c%0d", k), int'(out_valid), (k == 6) ? 1 : 0);
      chk($sformatf("in_ready_c%0d", k), int'(in_ready), 0);
    end
    wait_done();

    send(2, 3, 0, 0, 100);
    wait_done();
    send(2, 3, 64, 0, 125);
    wait_done();

    // Half-LSB rounding.
    set_px(5, 5, 0, 1, 0, 0);
    send(5, 5, 128, 0, 1);
    wait_done();
    set_px(5, 5, 0, -1, 0, 0);
    send(5, 5, 128, 0, 0);
    wait_done();

    // Extremes.
    set_px(7, 8, 32767, 32767, 32767, 32767);
    send(7, 8, 255, 255, 32767);
    wait_done();
    set_px(7, 8, -32768, -32768, -32768, -32768);
    send(7, 8, 255, 255, -32768);
    wait_done();
    chk("idle_in_ready", int'(in_ready), 1);

    // Backpressure in OUT.
    out_ready = 1'b0;
    send(2, 3, 128, 128, 250);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_out_valid_seen", int'(seen), 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_data", int'(out_data), 250);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_rd_en", int'(rd_en), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", int'(in_ready), 1);
    chk("bp_out_valid_after", int'(out_valid), 0);

    // Reset while fetch slot 2 is on the read port.
    set_px(7, 8, 32767, 32767, 32767, 32767);
    send(7, 8, 255, 255, 32767);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    addr_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_rd_en", int'(rd_en), 0);
    send(2, 3, 128, 128, 250);
    wait_done();

    // Neighbour clamping at the tile edges.
    put(15, 3, 40);
    put(15, 4, 80);
    send(15, 3, 128, 128, 60);
    wait_done();
    put(2, 15, -10);
    put(3, 15, 30);
    send(2, 15, 128, 200, 10);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
